dcp_mem_dump: RTL and testbench
===============================

Name: dcp_mem_dump

Overview:
- Child command engine of the debug control unit. Serves the memory-dump commands 'D' (data memory) and 'I' (instruction memory) from one parametrised FSM.
- Takes an optional hex start address from the scan unit, reads DUMP_WORDS consecutive words from the selected memory over the shared addr bus, and prints each word through the print unit.
- Keeps a separate continuation pointer per memory, so a bare command resumes where the previous dump of that memory ended.

Parameters:
- ADDR_W, 32, width of addr bus and pointers
- DATA_W, 32, memory word width (≤32; zero-extended onto dout_tx)
- DUMP_WORDS, 8, words printed per command (≥1)
- ADDR_STEP, 1, pointer increment per word
- RD_LAT, 1, cycles from addr stable to memory data valid (≥0)
- CMD_D_CODE, 8'h44, sel_mode value selecting data memory
- CMD_I_CODE, 8'h49, sel_mode value selecting instruction memory

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sel_mode  in  8  mode code from the parent FSM
- finish  out  1  command complete; parent returns to INIT
- req_rx  out  1  scan request
- type_rx  out  1  scan type: 1 = hex word, 0 = char
- ack_rx  in  1  scan done pulse
- flag_rx  in  1  with ack_rx: 1 = number parsed, 0 = empty line
- din_rx  in  32  scanned value
- req_tx  out  1  print request
- type_tx  out  1  print type: 1 = 8 hex digits, 0 = ASCII char dout_tx[7:0]
- dout_tx  out  32  print payload
- ack_tx  in  1  print done pulse
- addr  out  ADDR_W  memory read address
- dout_dm  in  DATA_W  data memory read data
- dout_im  in  DATA_W  instruction memory read data

Behaviour:
- Reset (synchronous): state=IDLE. finish, req_rx, req_tx, type_rx, type_tx = 0. dout_tx = 0, addr = 0. ptr_d = ptr_i = 0. A reset mid-dump abandons the dump immediately with no further requests.
- Source latch: src=I if sel_mode==CMD_I_CODE, else D. Latched when leaving IDLE.
- IDLE: go to ARG when sel_mode ∈ {D code, I code}.
- ARG: req_rx=1, type_rx=1. Request held until the ack_rx cycle. On ack: flag_rx=1 → cur=din_rx[ADDR_W-1:0]; flag_rx=0 → cur=ptr_src. Then RD with cnt=0. req_rx deasserts the cycle after ack.
- RD: addr=cur. Wait RD_LAT cycles (RD_LAT=0: same cycle). Capture the selected dout_* into a data register. Go to P_ADDR.
- P_ADDR: print cur (type 1).
- P_SEP: print '-' (8'h2D, type 0).
- P_DATA: print the data register (type 1).
- P_NL: print 8'h0A (type 0).
- Print states: req_tx=1 with payload stable until the ack_tx cycle. Advance on ack_tx; req_tx drops for at least one cycle between items.
- After P_NL: cur += ADDR_STEP, wrapping mod 2^ADDR_W. cnt++. If cnt==DUMP_WORDS → DONE, and ptr_src = cur (post-increment). Else → RD.
- DONE: finish=1, all requests 0. Held until sel_mode ∉ {D, I}, then IDLE.
- finish=0 in all other states.
- Abort: sel_mode leaves the latched code in any non-IDLE state other than DONE → IDLE next cycle. Requests drop; pointers unchanged.
- Address wrap: 0xFFFFFFFF + 1 → 0x00000000 with no error.
- The other pointer is never modified by a dump.
- addr holds its last value outside RD.
- Acks arriving outside a state that requests them are ignored.

Decomposition:
- Shared package dcp_pkg: command codes (D, I, R, P, ...), print type constants (TYPE_CHAR, TYPE_HEX), ASCII constants ('-', LF, ':'), and the state enumeration.
- One sub-module: dcp_print_seq, a generic "emit one item via req/ack" helper (payload, type, start, done). Reused by the four print states and later by the R command engine.

Test Plan:
- 'D', arg 0x10, dout_dm=addr*3, RD_LAT=1 → 8 lines "00000010-00000030\n" … "00000017-00000045". finish rises after the 8th LF ack; ptr_d=0x18.
- Then 'D', empty line (flag_rx=0) → dump starts at 0x18, ends at 0x1F; ptr_d=0x20; ptr_i still 0.
- 'I', empty line → reads dout_im starting at 0x0; ptr_i=8; ptr_d unchanged at 0x20.
- 'D', arg 0xFFFFFFFE, DUMP_WORDS=4 → addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; ptr_d=2.
- Mid-dump (after 3rd word) sel_mode → 8'h00 → req_tx low next cycle, state IDLE, ptr_d unchanged. Repeat with rst pulsed → all outputs 0, both pointers 0.
- Delayed ack_tx (random 0–20 cycles) → payload and req_tx stable until ack, with no duplicated or skipped items.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared definitions for the debug control unit command engines:
// command codes, print types, ASCII constants and the dump FSM states.
package dcp_pkg;

    localparam logic [7:0] CMD_D = 8'h44;  // 'D' dump data memory
    localparam logic [7:0] CMD_I = 8'h49;  // 'I' dump instruction memory
    localparam logic [7:0] CMD_R = 8'h52;  // 'R' register dump
    localparam logic [7:0] CMD_P = 8'h50;  // 'P' program load

    localparam logic TYPE_CHAR = 1'b0;     // print dout_tx[7:0] as one ASCII char
    localparam logic TYPE_HEX  = 1'b1;     // print dout_tx as 8 hex digits

    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_RD,
        ST_P_ADDR,
        ST_P_SEP,
        ST_P_DATA,
        ST_P_NL,
        ST_DONE
    } dump_state_e;

    typedef enum logic {
        SRC_D,
        SRC_I
    } dump_src_e;

endpackage

// File: rtl/dcp_mem_dump_if.sv
// Bus bundle between the memory-dump engine and its environment
// (parent FSM, scan unit, print unit, memories).
interface dcp_mem_dump_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [7:0]        sel_mode;
    logic              finish;
    logic              req_rx;
    logic              type_rx;
    logic              ack_rx;
    logic              flag_rx;
    logic [31:0]       din_rx;
    logic              req_tx;
    logic              type_tx;
    logic [31:0]       dout_tx;
    logic              ack_tx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout_dm;
    logic [DATA_W-1:0] dout_im;

    // Engine side
    modport master (
        input  sel_mode,
        output finish,
        output req_rx, type_rx,
        input  ack_rx, flag_rx, din_rx,
        output req_tx, type_tx, dout_tx,
        input  ack_tx,
        output addr,
        input  dout_dm, dout_im
    );

    // Environment side
    modport slave (
        output sel_mode,
        input  finish,
        input  req_rx, type_rx,
        output ack_rx, flag_rx, din_rx,
        input  req_tx, type_tx, dout_tx,
        output ack_tx,
        input  addr,
        output dout_dm, dout_im
    );

endinterface

// File: rtl/dcp_print_seq.sv
// Emits one print item over the req/ack handshake. While start is high and
// no request is pending, latches payload/type and raises req_tx; the ack
// drops it again, so consecutive items always see one idle cycle between
// them. Dropping start cancels a pending request on the next edge.
module dcp_print_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] payload,
    input  logic        ptype,
    input  logic        ack_tx,
    output logic        req_tx,
    output logic        type_tx,
    output logic [31:0] dout_tx,
    output logic        done
);

    // Stray acks are ignored because done requires an outstanding request.
    assign done = req_tx & ack_tx;

    // Request/payload register: launch, hold until ack, cancel when start drops
    always_ff @(posedge clk) begin
        if (rst) begin
            req_tx  <= 1'b0;
            type_tx <= 1'b0;
            dout_tx <= '0;
        end else if (!start) begin
            req_tx <= 1'b0;
        end else if (req_tx) begin
            if (ack_tx) begin
                req_tx <= 1'b0;
            end
        end else begin
            req_tx  <= 1'b1;
            type_tx <= ptype;
            dout_tx <= payload;
        end
    end

endmodule

// File: rtl/dcp_mem_dump.sv
// Memory-dump command engine ('D' data memory, 'I' instruction memory).
// Reads DUMP_WORDS words starting at a scanned or remembered address and
// prints "AAAAAAAA-DDDDDDDD\n" per word. Each memory has its own
// continuation pointer so a bare command resumes the previous dump.
module dcp_mem_dump
    import dcp_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DUMP_WORDS = 8,
    parameter int unsigned ADDR_STEP  = 1,
    parameter int unsigned RD_LAT     = 1,
    parameter logic [7:0]  CMD_D_CODE = CMD_D,
    parameter logic [7:0]  CMD_I_CODE = CMD_I
) (
    input  logic           clk,
    input  logic           rst,
    dcp_mem_dump_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DUMP_WORDS + 1);
    localparam int unsigned LAT_W = $clog2(RD_LAT + 2);

    dump_state_e       state, state_next;
    dump_src_e         src;
    logic [ADDR_W-1:0] cur, cur_inc, ptr_d, ptr_i, ptr_src, addr_q, addr_o;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        src_code;
    logic              cmd_hit, abort, rd_ready;
    logic              finish_o, req_rx_o, type_rx_o;
    logic              pr_start, pr_type, pr_done;
    logic [31:0]       pr_payload;

    assign cmd_hit  = (bus.sel_mode == CMD_D_CODE) || (bus.sel_mode == CMD_I_CODE);
    assign src_code = (src == SRC_I) ? CMD_I_CODE : CMD_D_CODE;
    assign abort    = (state != ST_IDLE) && (state != ST_DONE) && (bus.sel_mode != src_code);
    assign ptr_src  = (src == SRC_I) ? ptr_i : ptr_d;
    assign cur_inc  = cur + ADDR_W'(ADDR_STEP);
    assign cnt_inc  = cnt + CNT_W'(1);
    assign rd_ready = (lat_cnt == LAT_W'(RD_LAT));
    // Address is driven straight from cur in RD so RD_LAT=0 reads in the
    // same cycle; outside RD it holds the last value presented.
    assign addr_o   = (state == ST_RD) ? cur : addr_q;

    assign bus.addr    = addr_o;
    assign bus.finish  = finish_o;
    assign bus.req_rx  = req_rx_o;
    assign bus.type_rx = type_rx_o;

    dcp_print_seq u_print (
        .clk     (clk),
        .rst     (rst),
        .start   (pr_start),
        .payload (pr_payload),
        .ptype   (pr_type),
        .ack_tx  (bus.ack_tx),
        .req_tx  (bus.req_tx),
        .type_tx (bus.type_tx),
        .dout_tx (bus.dout_tx),
        .done    (pr_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request/print decode
    always_comb begin
        state_next = state;
        finish_o   = 1'b0;
        req_rx_o   = 1'b0;
        type_rx_o  = 1'b0;
        pr_start   = 1'b0;
        pr_type    = TYPE_CHAR;
        pr_payload = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_hit) state_next = ST_ARG;
            end
            ST_ARG: begin
                req_rx_o  = 1'b1;
                type_rx_o = 1'b1;
                if (bus.ack_rx) state_next = ST_RD;
            end
            ST_RD: begin
                if (rd_ready) state_next = ST_P_ADDR;
            end
            ST_P_ADDR: begin
                pr_start   = 1'b1;
                pr_type    = TYPE_HEX;
                pr_payload = 32'(cur);
                if (pr_done) state_next = ST_P_SEP;
            end
            ST_P_SEP: begin
                pr_start   = 1'b1;
                pr_type    = TYPE_CHAR;
                pr_payload = {24'h0, ASCII_DASH};
                if (pr_done) state_next = ST_P_DATA;
            end
            ST_P_DATA: begin
                pr_start   = 1'b1;
                pr_type    = TYPE_HEX;
                pr_payload = 32'(data_q);
                if (pr_done) state_next = ST_P_NL;
            end
            ST_P_NL: begin
                pr_start   = 1'b1;
                pr_type    = TYPE_CHAR;
                pr_payload = {24'h0, ASCII_LF};
                if (pr_done) state_next = (cnt_inc == CNT_W'(DUMP_WORDS)) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                finish_o = 1'b1;
                if (!cmd_hit) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort overrides everything so requests drop on the next edge.
        if (abort) begin
            state_next = ST_IDLE;
            req_rx_o   = 1'b0;
            type_rx_o  = 1'b0;
            pr_start   = 1'b0;
        end
    end

    // Datapath: source latch, current address, word count, read data, pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            src     <= SRC_D;
            cur     <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            data_q  <= '0;
            ptr_d   <= '0;
            ptr_i   <= '0;
            addr_q  <= '0;
        end else begin
            addr_q <= addr_o;
            if (state == ST_IDLE && state_next == ST_ARG) begin
                src <= (bus.sel_mode == CMD_I_CODE) ? SRC_I : SRC_D;
            end
            if (state == ST_ARG && state_next == ST_RD) begin
                cur     <= bus.flag_rx ? ADDR_W'(bus.din_rx) : ptr_src;
                cnt     <= '0;
                lat_cnt <= '0;
            end
            if (state == ST_RD && state_next == ST_RD) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
            if (state == ST_RD && state_next == ST_P_ADDR) begin
                data_q <= (src == SRC_I) ? bus.dout_im : bus.dout_dm;
            end
            if (state == ST_P_NL && pr_done && !abort) begin
                cur     <= cur_inc;
                cnt     <= cnt_inc;
                lat_cnt <= '0;
                if (cnt_inc == CNT_W'(DUMP_WORDS)) begin
                    if (src == SRC_I) ptr_i <= cur_inc;
                    else              ptr_d <= cur_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcp_mem_dump.sv
// Directed bench for dcp_mem_dump: a table of dump commands with expected
// start addresses and resulting pointers, plus hand sequences for abort,
// mid-dump reset, stray acks and non-dump codes.
module tb_dcp_mem_dump;
    import dcp_pkg::*;

    typedef struct {
        logic [7:0]  code;
        logic        flag;
        logic [31:0] arg;
        logic [31:0] start;
        logic        is_i;
        logic [31:0] exp_ptr_d;
        logic [31:0] exp_ptr_i;
    } cmd_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    cmd_vec_t    vecs[5];
    cmd_vec_t    last_vec;

    dcp_mem_dump_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dcp_mem_dump #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DUMP_WORDS (8),
        .ADDR_STEP  (1),
        .RD_LAT     (1),
        .CMD_D_CODE (8'h44),
        .CMD_I_CODE (8'h49)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dm_word(input logic [31:0] a);
        return a * 32'd3;
    endfunction

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memories with one cycle of read latency
    always @(posedge clk) begin
        bus.dout_dm <= dm_word(bus.addr);
        bus.dout_im <= im_word(bus.addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic wait_req_tx(input string name, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req_tx === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, " req_tx timeout"}, 32'd0, 32'd1);
    endtask

    task automatic tx_item(input string name, input logic ty, input logic [31:0] pay);
        bit          seen, stable;
        logic        t0;
        logic [31:0] p0;
        int unsigned d;
        wait_req_tx(name, seen);
        if (!seen) return;
        t0 = bus.type_tx;
        p0 = bus.dout_tx;
        check({name, " type"}, 32'(t0), 32'(ty));
        check({name, " payload"}, p0, pay);
        d = $urandom_range(20, 0);
        stable = 1'b1;
        for (int i = 0; i < int'(d); i++) begin
            @(negedge clk);
            if (bus.req_tx !== 1'b1 || bus.type_tx !== t0 || bus.dout_tx !== p0) stable = 1'b0;
        end
        check({name, " hold"}, 32'(stable), 32'd1);
        bus.ack_tx = 1'b1;
        @(negedge clk);
        bus.ack_tx = 1'b0;
        check({name, " gap"}, 32'(bus.req_tx), 32'd0);
    endtask

    task automatic serve_word(input string tag, input logic [31:0] a, input logic is_i);
        tx_item({tag, " addr"}, TYPE_HEX, a);
        tx_item({tag, " sep"}, TYPE_CHAR, 32'h2D);
        tx_item({tag, " data"}, TYPE_HEX, is_i ? im_word(a) : dm_word(a));
        tx_item({tag, " nl"}, TYPE_CHAR, 32'h0A);
    endtask

    task automatic do_scan(input string tag, input logic [7:0] code, input logic flag,
                           input logic [31:0] arg, output bit ok);
        ok = 1'b0;
        bus.sel_mode = code;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.req_rx === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " scan req"}, 32'(ok), 32'd1);
        if (!ok) return;
        check({tag, " scan type"}, 32'(bus.type_rx), 32'd1);
        bus.flag_rx = flag;
        bus.din_rx  = arg;
        bus.ack_rx  = 1'b1;
        @(negedge clk);
        bus.ack_rx  = 1'b0;
        bus.flag_rx = 1'b0;
        bus.din_rx  = '0;
        check({tag, " scan drop"}, 32'(bus.req_rx), 32'd0);
        check({tag, " finish low"}, 32'(bus.finish), 32'd0);
    endtask

    task automatic run_cmd(input cmd_vec_t v, input int unsigned idx);
        bit    ok;
        string tag;
        tag = $sformatf("v%0d", idx);
        do_scan(tag, v.code, v.flag, v.arg, ok);
        if (ok) begin
            for (int w = 0; w < 8; w++) begin
                serve_word($sformatf("%s w%0d", tag, w), v.start + 32'(w), v.is_i);
            end
            check({tag, " finish"}, 32'(bus.finish), 32'd1);
            check({tag, " ptr_d"}, dut.ptr_d, v.exp_ptr_d);
            check({tag, " ptr_i"}, dut.ptr_i, v.exp_ptr_i);
        end
        bus.sel_mode = 8'h00;
        @(negedge clk);
        check({tag, " finish clear"}, 32'(bus.finish), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok, seen;

        vecs[0] = '{code: 8'h44, flag: 1'b1, arg: 32'h0000_0010, start: 32'h0000_0010,
                    is_i: 1'b0, exp_ptr_d: 32'h0000_0018, exp_ptr_i: 32'h0000_0000};
        vecs[1] = '{code: 8'h44, flag: 1'b0, arg: 32'h0000_DEAD, start: 32'h0000_0018,
                    is_i: 1'b0, exp_ptr_d: 32'h0000_0020, exp_ptr_i: 32'h0000_0000};
        vecs[2] = '{code: 8'h49, flag: 1'b0, arg: 32'h0000_0000, start: 32'h0000_0000,
                    is_i: 1'b1, exp_ptr_d: 32'h0000_0020, exp_ptr_i: 32'h0000_0008};
        vecs[3] = '{code: 8'h44, flag: 1'b1, arg: 32'hFFFF_FFFE, start: 32'hFFFF_FFFE,
                    is_i: 1'b0, exp_ptr_d: 32'h0000_0006, exp_ptr_i: 32'h0000_0008};
        vecs[4] = '{code: 8'h49, flag: 1'b1, arg: 32'h0000_0100, start: 32'h0000_0100,
                    is_i: 1'b1, exp_ptr_d: 32'h0000_0006, exp_ptr_i: 32'h0000_0108};
        last_vec = '{code: 8'h44, flag: 1'b0, arg: 32'h0, start: 32'h0,
                     is_i: 1'b0, exp_ptr_d: 32'h0000_0008, exp_ptr_i: 32'h0};

        bus.sel_mode = 8'h00;
        bus.ack_rx   = 1'b0;
        bus.flag_rx  = 1'b0;
        bus.din_rx   = '0;
        bus.ack_tx   = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset finish", 32'(bus.finish), 32'd0);
        check("reset req_rx", 32'(bus.req_rx), 32'd0);
        check("reset type_rx", 32'(bus.type_rx), 32'd0);
        check("reset req_tx", 32'(bus.req_tx), 32'd0);
        check("reset type_tx", 32'(bus.type_tx), 32'd0);
        check("reset dout_tx", bus.dout_tx, 32'd0);
        check("reset addr", bus.addr, 32'd0);
        check("reset ptr_d", dut.ptr_d, 32'd0);
        check("reset ptr_i", dut.ptr_i, 32'd0);

        // A non-dump code must not start the engine
        bus.sel_mode = 8'h52;
        repeat (3) @(negedge clk);
        check("R code req_rx", 32'(bus.req_rx), 32'd0);
        check("R code state", 32'(dut.state), 32'(ST_IDLE));
        bus.sel_mode = 8'h00;

        // Stray acks in IDLE are ignored
        bus.ack_tx  = 1'b1;
        bus.ack_rx  = 1'b1;
        bus.flag_rx = 1'b1;
        bus.din_rx  = 32'h55;
        repeat (2) @(negedge clk);
        bus.ack_tx  = 1'b0;
        bus.ack_rx  = 1'b0;
        bus.flag_rx = 1'b0;
        bus.din_rx  = '0;
        check("stray req_tx", 32'(bus.req_tx), 32'd0);
        check("stray req_rx", 32'(bus.req_rx), 32'd0);
        check("stray state", 32'(dut.state), 32'(ST_IDLE));

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i], i);
        end

        // Abort after the third word of a bare 'D' resuming at 6
        do_scan("abort", 8'h44, 1'b0, 32'h0, ok);
        if (ok) begin
            for (int w = 0; w < 3; w++) begin
                serve_word($sformatf("abort w%0d", w), 32'h6 + 32'(w), 1'b0);
            end
            wait_req_tx("abort w3", seen);
            if (seen) begin
                check("abort w3 addr", bus.dout_tx, 32'h9);
                bus.sel_mode = 8'h00;
                @(negedge clk);
                check("abort req_tx", 32'(bus.req_tx), 32'd0);
                check("abort state", 32'(dut.state), 32'(ST_IDLE));
                check("abort finish", 32'(bus.finish), 32'd0);
                check("abort ptr_d", dut.ptr_d, 32'h6);
                check("abort ptr_i", dut.ptr_i, 32'h108);
            end
        end
        bus.sel_mode = 8'h00;
        repeat (2) @(negedge clk);

        // Reset in the middle of an 'I' dump
        do_scan("rstdump", 8'h49, 1'b0, 32'h0, ok);
        if (ok) begin
            serve_word("rstdump w0", 32'h108, 1'b1);
            wait_req_tx("rstdump w1", seen);
        end
        rst = 1'b1;
        bus.sel_mode = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset req_tx", 32'(bus.req_tx), 32'd0);
        check("mid reset req_rx", 32'(bus.req_rx), 32'd0);
        check("mid reset finish", 32'(bus.finish), 32'd0);
        check("mid reset type_tx", 32'(bus.type_tx), 32'd0);
        check("mid reset dout_tx", bus.dout_tx, 32'd0);
        check("mid reset addr", bus.addr, 32'd0);
        check("mid reset ptr_d", dut.ptr_d, 32'd0);
        check("mid reset ptr_i", dut.ptr_i, 32'd0);

        // Bare 'D' after reset starts from 0
        run_cmd(last_vec, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
